// File: rtl/spi_pkt_pkg.sv
// Shared types and byte-layout constants for the SPI sensor packet receiver.
package spi_pkt_pkg;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_LEN  = 3'd1,
    ERR_HDR  = 3'd2,
    ERR_ID   = 3'd3,
    ERR_CSUM = 3'd4
  } err_t;

  localparam logic [7:0] HEADER_DEF = 8'hAA;

  localparam int HDR_OFS   = 0;
  localparam int ID_OFS    = 1;
  localparam int FIELD_OFS = 2;

  function automatic int flags_ofs(input int nf);
    return FIELD_OFS + 2 * nf;
  endfunction

  function automatic int trl_ofs(input int nf);
    return FIELD_OFS + 2 * nf + 1;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one async input with a history flop for
// single-cycle rise/fall strobes in the clk domain.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist   <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/spi_sensor_pkt_rx.sv
// Oversampled SPI mode-0 slave that receives fixed-length sensor packets and
// commits them into per-channel registers. Define SPI_PKT_CHECKSUM_EN to
// enforce the XOR trailer byte.
module spi_sensor_pkt_rx
  import spi_pkt_pkg::*;
#(
  parameter int         NUM_CH      = 2,
  parameter int         NUM_FIELDS  = 6,
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cs_n,
  input  logic                           sck,
  input  logic                           sdi,
  output logic [NUM_CH*NUM_FIELDS*16-1:0] ch_fields,
  output logic [NUM_CH*8-1:0]            ch_flags,
  output logic [NUM_CH-1:0]              ch_update,
  output logic                           initialized,
  output logic                           error,
  output logic [2:0]                     err_code,
  output logic [15:0]                    pkt_count,
  output logic [7:0]                     err_count
);

  localparam int PKT_BYTES = 2 * NUM_FIELDS + 4;
  localparam int BCW       = $clog2(PKT_BYTES + 2);
  localparam int BIW       = $clog2(PKT_BYTES);
  localparam int FLAGS_OFS = flags_ofs(NUM_FIELDS);
  localparam logic [BCW-1:0] LEN_OK  = BCW'(PKT_BYTES);
  localparam logic [BCW-1:0] LEN_MAX = BCW'(PKT_BYTES + 1);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic unused_sync;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi_sync (
    .clk(clk), .rst_n(rst_n), .d(sdi), .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall));

  assign unused_sync = ^{sck_q, sck_fall, cs_q, sdi_rise, sdi_fall};

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [6:0]     rx_shift;
  logic [7:0]     pkt_buf [PKT_BYTES];
  err_t           chk_code;

`ifdef SPI_PKT_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < PKT_BYTES - 1; i++) csum = csum ^ pkt_buf[i];
  end
`endif

  // Priority-ordered validation of the captured packet, evaluated in CHECK.
  always_comb begin
    chk_code = ERR_NONE;
    if (byte_cnt != LEN_OK)                  chk_code = ERR_LEN;
    else if (pkt_buf[HDR_OFS] != HEADER)     chk_code = ERR_HDR;
    else if (pkt_buf[ID_OFS] >= 8'(NUM_CH))  chk_code = ERR_ID;
`ifdef SPI_PKT_CHECKSUM_EN
    else if (csum != pkt_buf[trl_ofs(NUM_FIELDS)]) chk_code = ERR_CSUM;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      rx_shift    <= '0;
      for (int i = 0; i < PKT_BYTES; i++) pkt_buf[i] <= '0;
      ch_fields   <= '0;
      ch_flags    <= '0;
      ch_update   <= '0;
      initialized <= 1'b0;
      error       <= 1'b0;
      err_code    <= '0;
      pkt_count   <= '0;
      err_count   <= '0;
    end else begin
      ch_update <= '0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= RECV;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_shift <= '0;
          end
        end
        RECV: begin
          // cs_n deassertion takes precedence over a coincident sck edge.
          if (cs_rise) begin
            state <= CHECK;
          end else if (cs_fall) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_shift <= '0;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[5:0], sdi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt < LEN_OK) pkt_buf[byte_cnt[BIW-1:0]] <= {rx_shift, sdi_s};
              if (byte_cnt != LEN_MAX) byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          state <= IDLE;
          if (chk_code == ERR_NONE) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (pkt_buf[ID_OFS] == 8'(c)) begin
                for (int f = 0; f < NUM_FIELDS; f++)
                  ch_fields[(c*NUM_FIELDS+f)*16 +: 16] <=
                    {pkt_buf[FIELD_OFS+2*f], pkt_buf[FIELD_OFS+2*f+1]};
                ch_flags[c*8 +: 8] <= pkt_buf[FLAGS_OFS];
                ch_update[c]       <= 1'b1;
              end
            end
            initialized <= 1'b1;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            pkt_count   <= pkt_count + 16'd1;
          end else begin
            error    <= 1'b1;
            err_code <= chk_code;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sensor_pkt_rx.sv
// Randomised bench for spi_sensor_pkt_rx: drives SPI frames at SCK=clk/8 and
// compares every output against a packet-level reference model.
module tb_spi_sensor_pkt_rx;

  localparam int NCH = 2;
  localparam int NF  = 6;
  localparam int PKT = 2 * NF + 4;
  localparam int FW  = NCH * NF * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic [FW-1:0]    ch_fields;
  logic [NCH*8-1:0] ch_flags;
  logic [NCH-1:0]   ch_update;
  logic             initialized, error;
  logic [2:0]       err_code;
  logic [15:0]      pkt_count;
  logic [7:0]       err_count;

  spi_sensor_pkt_rx #(.NUM_CH(NCH), .NUM_FIELDS(NF), .HEADER(8'hAA), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .sdi(sdi),
    .ch_fields(ch_fields), .ch_flags(ch_flags), .ch_update(ch_update),
    .initialized(initialized), .error(error), .err_code(err_code),
    .pkt_count(pkt_count), .err_count(err_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int upd_total = 0;

  // Reference model state
  logic [7:0]       tx [0:31];
  logic [FW-1:0]    m_fields;
  logic [NCH*8-1:0] m_flags;
  logic             m_init, m_err;
  logic [2:0]       m_code;
  logic [15:0]      m_pkt;
  logic [7:0]       m_ecnt;

  always @(negedge clk) if (ch_update != '0) upd_total++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fields = '0; m_flags = '0; m_init = 0; m_err = 0;
    m_code = 0; m_pkt = 0; m_ecnt = 0;
  endtask

  function automatic logic [2:0] model_code(input int nb);
    logic [7:0] x;
    if (nb != PKT) return 3'd1;
    if (tx[0] != 8'hAA) return 3'd2;
    if (int'(tx[1]) >= NCH) return 3'd3;
`ifdef SPI_PKT_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < PKT - 1; i++) x ^= tx[i];
    if (x != tx[PKT-1]) return 3'd4;
`else
    x = 8'h00;
`endif
    return 3'd0;
  endfunction

  // Returns the ch_update mask the packet should produce.
  function automatic logic [NCH-1:0] model_apply(input int nb);
    logic [2:0] code;
    int id;
    code = model_code(nb);
    if (code == 3'd0) begin
      id = int'(tx[1]);
      for (int f = 0; f < NF; f++)
        m_fields[(id*NF+f)*16 +: 16] = {tx[2+2*f], tx[3+2*f]};
      m_flags[id*8 +: 8] = tx[2+2*NF];
      m_init = 1; m_err = 0; m_code = 0; m_pkt = m_pkt + 16'd1;
      return NCH'(1) << id;
    end
    m_err = 1; m_code = code;
    if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
    return '0;
  endfunction

  task automatic fix_trl();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < PKT - 1; i++) x ^= tx[i];
    tx[PKT-1] = x;
  endtask

  task automatic make_good(input int id);
    tx[0] = 8'hAA;
    tx[1] = 8'(id);
    for (int i = 2; i < 32; i++) tx[i] = 8'($urandom_range(0, 255));
    fix_trl();
  endtask

  // Assert cs_n and clock out nb bytes plus xbits stray bits; leaves cs_n low.
  task automatic spi_frame(input int nb, input int xbits);
    cs_n = 1'b0;
    #100;
    for (int i = 0; i < nb; i++)
      for (int b = 7; b >= 0; b--) begin
        sdi = tx[i][b]; #40; sck = 1'b1; #40; sck = 1'b0;
      end
    for (int b = 0; b < xbits; b++) begin
      sdi = 1'($urandom_range(0, 1)); #40; sck = 1'b1; #40; sck = 1'b0;
    end
    #40;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".fields"}, 256'(ch_fields), 256'(m_fields));
    chk({tag, ".flags"},  256'(ch_flags),  256'(m_flags));
    chk({tag, ".init"},   256'(initialized), 256'(m_init));
    chk({tag, ".error"},  256'(error),     256'(m_err));
    chk({tag, ".code"},   256'(err_code),  256'(m_code));
    chk({tag, ".pkt"},    256'(pkt_count), 256'(m_pkt));
    chk({tag, ".ecnt"},   256'(err_count), 256'(m_ecnt));
  endtask

  // Deassert cs_n just after a clk edge, then confirm the update pulse lands
  // exactly SYNC_STAGES+1 edges after the first edge sampling cs_n high.
  task automatic end_and_check(input int nb, input string tag);
    logic [NCH-1:0] exp_upd, seen_upd;
    logic [10:0]    trace;
    @(posedge clk); #2 cs_n = 1'b1;
    exp_upd = model_apply(nb);
    trace = '0; seen_upd = '0;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      trace[j] = |ch_update;
      seen_upd = seen_upd | ch_update;
    end
    chk({tag, ".trace"}, 256'(trace), (exp_upd != '0) ? 256'(11'b1 << 4) : 256'(0));
    chk({tag, ".upd"}, 256'(seen_upd), 256'(exp_upd));
    check_outputs(tag);
    @(posedge clk); #3;
  endtask

  task automatic send(input int nb, input int xbits, input string tag);
    spi_frame(nb, xbits);
    end_and_check(nb, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int kind, n, ub;
    model_reset();
    repeat (3) @(posedge clk);
    check_outputs("reset");
    chk("reset.upd", 256'(ch_update), 256'(0));
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk); #3;

    // Directed: known fields to channel 1
    tx[0] = 8'hAA; tx[1] = 8'h01;
    for (int f = 0; f < NF; f++) begin tx[2+2*f] = 8'h00; tx[3+2*f] = 8'(f + 1); end
    tx[2+2*NF] = 8'h03;
    fix_trl();
    send(PKT, 0, "good1");

    make_good(0); tx[0] = 8'h55; fix_trl();
    send(PKT, 0, "hdr");

    make_good(1);
    send(10, 3, "short");
    make_good(0);
    send(17, 0, "long");
    make_good(0);
    send(PKT, 0, "recover");

    make_good(NCH); fix_trl();
    send(PKT, 0, "badid");
    make_good(0); tx[PKT-1] ^= 8'h01;
    send(PKT, 0, "csum");

    // Reset in the middle of a packet
    make_good(1);
    spi_frame(7, 3);
    #3 rst_n = 1'b0;
    cs_n = 1'b1; sck = 1'b0;
    model_reset();
    repeat (2) @(posedge clk); #3;
    check_outputs("midrst");
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #3;

    // Back-to-back with 4 clk of cs_n high between frames
    ub = upd_total;
    make_good(0);
    spi_frame(PKT, 0);
    @(posedge clk); #2 cs_n = 1'b1;
    void'(model_apply(PKT));
    repeat (4) @(posedge clk);
    #1;
    make_good(1);
    send(PKT, 0, "b2b");
    chk("b2b.pulses", 256'(upd_total - ub), 256'(2));

    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        3: begin make_good($urandom_range(0, NCH-1)); tx[0] = 8'($urandom_range(0, 169)); fix_trl(); send(PKT, 0, "rnd.hdr"); end
        4: begin make_good($urandom_range(NCH, 255)); send(PKT, 0, "rnd.id"); end
        5: begin
          make_good($urandom_range(0, NCH-1));
          n = $urandom_range(1, 17);
          if (n == PKT) n = 17;
          send(n, $urandom_range(0, 7), "rnd.len");
        end
        6: begin make_good($urandom_range(0, NCH-1)); tx[PKT-1] ^= 8'($urandom_range(1, 255)); send(PKT, 0, "rnd.csum"); end
        default: begin make_good($urandom_range(0, NCH-1)); send(PKT, $urandom_range(0, 7), "rnd.good"); end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sensor_pkt_rx.md
Name: spi_sensor_pkt_rx

Overview:
Read-only SPI Mode 0 slave receiving fixed-length sensor packets from the MCU master. It serves multiple sensor channels addressed by an ID byte. SCK, CS_N and SDI are oversampled and synchronised into the single clk domain, so there is no SCK-clocked logic and no unsafe snapshot crossing. Validated packets update per-channel field registers. Status and error codes feed the downstream motion/display logic.

Parameters:
NUM_CH, 2, number of sensor channels (ID byte range 0..NUM_CH-1)
NUM_FIELDS, 6, signed 16-bit fields per packet (MSB first)
HEADER, 8'hAA, required first byte
SYNC_STAGES, 2, synchroniser depth for sck/cs_n/sdi (min 2)
PKT_BYTES (localparam), 2*NUM_FIELDS+4, total bytes: header, id, fields, flags, trailer

Ports:
clk  in  1  system clock; SCK must be <= clk/8
rst_n  in  1  asynchronous active-low reset
cs_n  in  1  SPI chip select, active low, async to clk
sck  in  1  SPI clock, async to clk
sdi  in  1  MOSI, async to clk
ch_fields  out  NUM_CH*NUM_FIELDS*16  per-channel field registers, channel c field f at [(c*NUM_FIELDS+f)*16 +: 16]
ch_flags  out  NUM_CH*8  last accepted flags byte per channel
ch_update  out  NUM_CH  one-cycle pulse when channel c's registers are committed
initialized  out  1  set by first good packet; cleared only by reset
error  out  1  high after a rejected packet; cleared by the next good packet
err_code  out  3  0 none, 1 length, 2 header, 3 bad id, 4 checksum
pkt_count  out  16  good-packet counter, wraps at 16'hFFFF->0
err_count  out  8  rejected-packet counter, saturates at 8'hFF

Behaviour:
- Reset (rst_n=0, async): all outputs 0. FSM to IDLE. Synchronisers preset to cs_n=1, sck=0.
- Synchronise sck, cs_n and sdi through SYNC_STAGES flops, plus one history flop for edge detection.
- Rising sck = synced sck 1 with history 0. Sample synced sdi on that same cycle.
- IDLE: on synced cs_n falling edge, go to RECV and clear bit_cnt, byte_cnt and rx_shift.
- RECV, on each sck rising edge:
  - shift MSB-first;
  - on the 8th bit, write the byte into buf[byte_cnt] and increment byte_cnt;
  - byte_cnt saturates at PKT_BYTES+1; bytes beyond PKT_BYTES are discarded and mark overlength.
- RECV, on synced cs_n rising edge: go to CHECK. Any partial byte is discarded.
- Simultaneous sck rise and cs_n rise in the same cycle: cs_n wins and the bit is dropped.
- cs_n falling edge seen while in RECV (glitch): restart reception and clear counters.
- CHECK lasts 1 cycle, then returns to IDLE. Checks in priority order:
  - byte_cnt != PKT_BYTES -> code 1;
  - buf[0] != HEADER -> code 2;
  - buf[1] >= NUM_CH -> code 3;
  - checksum fail -> code 4 (CHECKSUM_EN only).
- Good packet, committed on the CHECK->IDLE edge:
  - load the addressed channel's fields and flags;
  - pulse ch_update[id] for exactly 1 cycle;
  - set initialized; clear error and err_code; increment pkt_count.
  - Other channels hold their values.
- Rejected packet:
  - all channel registers hold;
  - error=1, err_code set, err_count increments (saturating);
  - initialized is unchanged.
- Latency: with k = first clk edge sampling cs_n high at the pin, ch_update and the new register values appear at edge k+SYNC_STAGES+1.
- Reset mid-packet: the packet is lost; the FSM returns to IDLE and waits for a fresh cs_n falling edge.

Optional Feature:
SPI_PKT_CHECKSUM_EN
- Defined: buf[PKT_BYTES-1] must equal the XOR of bytes 0..PKT_BYTES-2, else err_code 4.
- Undefined: the trailer byte is received but ignored; err_code 4 is never produced.

Decomposition:
- Package spi_pkt_pkg holds:
  - state enum (IDLE, RECV, CHECK);
  - err_code enum;
  - HEADER default;
  - byte offset constants (HDR_OFS=0, ID_OFS=1, FIELD_OFS=2, flags/trailer offsets derived from NUM_FIELDS).
- One sub-module spi_in_sync: parameterised SYNC_STAGES synchroniser with a one-cycle rising/falling edge output. Instantiated for sck and cs_n; sdi uses the level output only.

Test Plan:
- Reset, then a good packet with id=1, fields 0x0001..0x0006, flags 0x03 -> ch_update=2'b10 for 1 cycle, channel 1 fields match, channel 0 stays 0, initialized=1, pkt_count=1.
- Header 0x55 -> error=1, err_code=2, err_count=1, all channel registers unchanged, no ch_update pulse.
- cs_n raised after 10 bytes + 3 bits -> err_code=1; then 17 bytes -> err_code=1; a following good packet clears error to 0.
- id=NUM_CH (2) -> err_code=3. With SPI_PKT_CHECKSUM_EN, trailer corrupted by XOR 0x01 -> err_code=4; without the macro, the same packet is accepted.
- Back-to-back packets to id 0 then id 1 with minimum cs_n-high time of 4 clk, at SCK=clk/8 -> both accepted and pkt_count=2; rst_n pulsed mid-packet -> all outputs 0 and the next packet is accepted.
